// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state for the trailing XOR byte.
package imem_loader_pkg;

    localparam int IMEM_DEPTH_DEF  = 256;
    localparam int IMEM_ADDR_W_DEF = 8;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

    typedef struct packed {
        logic rx_ready;
        logic busy;
        logic done;
        logic cpu_hold;
    } flags_t;

    // Status flags implied by being in a given state.
    function automatic flags_t state_flags(input state_t s);
        flags_t f;
        f.rx_ready = 1'b0;
        f.busy     = 1'b0;
        f.done     = 1'b0;
        f.cpu_hold = 1'b1;
        case (s)
            LOAD: begin
                f.rx_ready = 1'b1;
                f.busy     = 1'b1;
            end
            WRITE: f.busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                f.rx_ready = 1'b1;
                f.busy     = 1'b1;
            end
`endif
            DONE: begin
                f.done     = 1'b1;
                f.cpu_hold = 1'b0;
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word and flags
// the byte that completes it; o_word is valid alongside o_word_done.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [1:0]  r_idx;
    logic [31:0] r_shift;

    // Bytes enter at the top and move down, so byte 0 ends up in bits 7:0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= 2'd0;
            r_shift <= 32'd0;
        end else if (i_clr) begin
            r_idx   <= 2'd0;
            r_shift <= 32'd0;
        end else if (i_en) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {i_data, r_shift[31:8]};
        end
    end

    assign o_word      = {i_data, r_shift[31:8]};
    assign o_word_done = i_en && (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int ADDR_W     = IMEM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W + 1)'(1);

    state_t            r_state;
    state_t            w_nxt;
    flags_t            r_flags;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_error;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_widx;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic              w_acc;
    logic              w_idle_like;
    logic              w_count_ok;
    logic              w_begin;
    logic [ADDR_W:0]   w_widx_inc;
    logic [31:0]       w_word;
    logic              w_word_done;

    assign w_acc       = rx_valid && r_flags.rx_ready;
    assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
    assign w_count_ok  = (word_count != '0) && (word_count <= L_DEPTH);
    assign w_begin     = w_idle_like && start && w_count_ok;
    assign w_widx_inc  = r_widx + L_ONE;

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (w_begin),
        .i_en        (w_acc && (r_state == LOAD)),
        .i_data      (rx_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (w_begin) w_nxt = LOAD;
            LOAD:       if (w_word_done) w_nxt = WRITE;
            WRITE: begin
                if (w_widx_inc == r_count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_nxt = CHECK;
`else
                    w_nxt = DONE;
`endif
                end else begin
                    w_nxt = LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:      if (w_acc) w_nxt = DONE;
`endif
            default:    w_nxt = IDLE;
        endcase
    end

    // Flags and the write strobe are registered from the next state, so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_flags <= '{rx_ready: 1'b0, busy: 1'b0, done: 1'b0, cpu_hold: 1'b1};
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_error <= 1'b0;
            r_count <= '0;
            r_widx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor   <= 8'd0;
`endif
        end else begin
            r_state <= w_nxt;
            r_flags <= state_flags(w_nxt);
            r_we    <= (w_nxt == WRITE);
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        if (w_count_ok) begin
                            r_count <= word_count;
                            r_widx  <= '0;
                            r_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_xor   <= 8'd0;
`endif
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_word_done) begin
                        r_addr  <= r_widx[ADDR_W-1:0];
                        r_wdata <= w_word;
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (w_acc) r_xor <= r_xor ^ rx_data;
`endif
                end
                WRITE: r_widx <= w_widx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: if (w_acc && (rx_data != r_xor)) r_error <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign rx_ready   = r_flags.rx_ready;
    assign busy       = r_flags.busy;
    assign done       = r_flags.done;
    assign cpu_hold   = r_flags.cpu_hold;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a transaction-level model compared
// every cycle; set IMEM_LOADER_CHECKSUM_EN to exercise the checksum byte.
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: what the outputs must be after the most recent clock edge.
    bit          m_active, m_done, m_err, m_wp, m_ck;
    int          m_count, m_bytes, m_writes;
    logic [7:0]  m_xor;
    logic [31:0] m_word;
    logic [AW-1:0] m_addr;
    logic [31:0] m_wdata;

    logic [31:0] mem [DEPTH];
    int          we_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_err = 0; m_wp = 0; m_ck = 0;
        m_count = 0; m_bytes = 0; m_writes = 0;
        m_xor = 8'd0; m_word = 32'd0; m_addr = '0; m_wdata = 32'd0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_active && !m_wp});
        chk("imem_we", {31'd0, imem_we}, {31'd0, m_wp});
        chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_addr});
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("error", {31'd0, error}, {31'd0, m_err});
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !m_done});
        if (imem_we === 1'b1) begin
            mem[imem_addr] = imem_wdata;
            we_pulses++;
        end
        if (!reset) begin
            if (m_wp) begin
                m_wp = 0;
                m_writes++;
                if (m_writes == m_count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    m_ck = 1;
`else
                    m_active = 0;
                    m_done = 1;
`endif
                end
            end else if (m_active) begin
                if (rx_valid) begin
                    if (m_ck) begin
                        if (rx_data != m_xor) m_err = 1;
                        m_ck = 0;
                        m_active = 0;
                        m_done = 1;
                    end else begin
                        m_word[8*(m_bytes%4) +: 8] = rx_data;
                        m_xor = m_xor ^ rx_data;
                        m_bytes++;
                        if (m_bytes % 4 == 0) begin
                            m_wp = 1;
                            m_addr = m_writes[AW-1:0];
                            m_wdata = m_word;
                        end
                    end
                end
            end else if (start) begin
                if (word_count >= 1 && word_count <= DEPTH) begin
                    m_active = 1; m_done = 0; m_err = 0;
                    m_count = int'(word_count);
                    m_bytes = 0; m_writes = 0; m_xor = 8'd0;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        word_count = n[AW:0];
        tick();
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random valid plus stray starts
    task automatic send_bytes(input logic [7:0] q[$], input int mode);
        int i = 0;
        int cyc = 0;
        while (i < q.size()) begin
            rx_valid = (mode == 0) || (mode == 1 && cyc % 2 == 0) ||
                       (mode == 2 && $urandom_range(0, 1) == 1);
            rx_data = rx_valid ? q[i] : 8'($urandom);
            if (mode == 2 && $urandom_range(0, 9) == 0) begin
                start = 1'b1;
                word_count = 9'($urandom_range(0, 300));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (rx_valid && rx_ready) i++;
            tick();
            cyc++;
            if (cyc > 20000) begin
                chk("send_timeout", i, q.size());
                break;
            end
        end
        rx_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        @(negedge clk);
        while (done !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
        tick();
    endtask

    task automatic run_load(input int n, input logic [31:0] words[$], input int mode, input bit bad_ck);
        logic [7:0]  q[$];
        logic [7:0]  x;
        logic [31:0] wd;
        x = 8'd0;
        do_start(n);
        foreach (words[w]) begin
            wd = words[w];
            for (int b = 0; b < 4; b++) begin
                q.push_back(wd[8*b +: 8]);
                x = x ^ wd[8*b +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        q.push_back(bad_ck ? (x ^ 8'h01) : x);
`endif
        send_bytes(q, mode);
        wait_done();
    endtask

    initial begin
        logic [31:0] ws[$];
        logic [7:0]  q6[$];
        int p0;
        int n;

        clear_mem();
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("reset_rx_ready", {31'd0, rx_ready}, 32'd0);

        // Two-word program, continuous stream
        ws = '{32'h0000_0013, 32'h0010_0093};
        p0 = we_pulses;
        run_load(2, ws, 0, 1'b0);
        chk("load_mem0", mem[0], 32'h0000_0013);
        chk("load_mem1", mem[1], 32'h0010_0093);
        chk("load_pulses", we_pulses - p0, 32'd2);
        chk("load_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("load_error", {31'd0, error}, 32'd0);

        // Same program with rx_valid toggling
        do_reset();
        clear_mem();
        p0 = we_pulses;
        run_load(2, ws, 1, 1'b0);
        chk("bp_mem0", mem[0], 32'h0000_0013);
        chk("bp_mem1", mem[1], 32'h0010_0093);
        chk("bp_pulses", we_pulses - p0, 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        run_load(2, ws, 0, 1'b1);
        chk("ck_bad_error", {31'd0, error}, 32'd1);
        chk("ck_bad_done", {31'd0, done}, 32'd1);
`endif

        // Out-of-range counts from IDLE
        do_reset();
        p0 = we_pulses;
        do_start(0);
        @(negedge clk);
        chk("bad0_error", {31'd0, error}, 32'd1);
        chk("bad0_busy", {31'd0, busy}, 32'd0);
        tick();
        do_reset();
        do_start(257);
        @(negedge clk);
        chk("bad257_error", {31'd0, error}, 32'd1);
        chk("bad257_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("bad_pulses", we_pulses - p0, 32'd0);

        // Reset after six bytes of a two-word load
        do_reset();
        clear_mem();
        p0 = we_pulses;
        do_start(2);
        q6 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        send_bytes(q6, 0);
        do_reset();
        repeat (4) tick();
        chk("midrst_pulses", we_pulses - p0, 32'd1);
        chk("midrst_mem0", mem[0], 32'h0000_0013);
        chk("midrst_mem1", mem[1], 32'hDEAD_BEEF);
        chk("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);

        // Full depth, word k = k
        clear_mem();
        ws.delete();
        for (int k = 0; k < DEPTH; k++) ws.push_back(32'(k));
        p0 = we_pulses;
        run_load(DEPTH, ws, 2, 1'b0);
        chk("full_last", mem[255], 32'h0000_00FF);
        chk("full_mid", mem[128], 32'h0000_0080);
        chk("full_pulses", we_pulses - p0, 32'd256);

        // Random programs started from DONE
        for (int it = 0; it < 10; it++) begin
            ws.delete();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) ws.push_back($urandom);
            clear_mem();
            run_load(n, ws, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
            chk("rand_last", mem[n-1], ws[n-1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
